// File: rtl/led_seq_pkg.sv
// Shared mode encoding for the LED pattern sequencer and anything that drives it.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    // Binary count starts from all-zeros; every other mode starts from a single lit LED.
    function automatic logic startIsZero(input mode_t m);
        return (m == MODE_COUNT);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable terminal-count prescaler: emits one advance pulse every (divide+1) enabled cycles.
module tick_prescaler
    import led_seq_pkg::*;
#(
    parameter int DIV_WIDTH      = 24,
    parameter int DEFAULT_DIVIDE = 400000
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_divide,
    input  logic                 i_clear,
    output logic                 o_adv
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_count;
    logic                 w_terminal;

    assign w_terminal = (r_count == r_div);
    assign o_adv      = i_enable & w_terminal & ~i_load & ~i_clear;

    // A load or clear restarts the count so a smaller new terminal value can never be overshot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div   <= DIV_WIDTH'(DEFAULT_DIVIDE);
            r_count <= '0;
        end else begin
            if (i_load) begin
                r_div <= i_divide;
            end
            if (i_load || i_clear) begin
                r_count <= '0;
            end else if (i_enable) begin
                r_count <= w_terminal ? '0 : r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: prescaled stepping through rotate/bounce/count patterns with a PWM brightness gate.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int DIV_WIDTH      = 24,
    parameter int DEFAULT_DIVIDE = 400000,
    parameter int PWM_WIDTH      = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] divide,
    input  logic                 load_divide,
    input  logic                 step,
    input  logic [PWM_WIDTH-1:0] brightness,
    output logic [NUM_LEDS-1:0]  leds,
    output logic                 tick,
    output logic                 wrap
);

    localparam logic [NUM_LEDS-1:0] ONE_HOT_START = NUM_LEDS'(1);

    mode_t                r_modeQ;
    logic [NUM_LEDS-1:0]  r_pattern;
    logic                 r_dirRight;
    logic [PWM_WIDTH-1:0] r_pwmCnt;

    mode_t                w_modeIn;
    logic                 w_modeChange;
    logic                 w_presAdv;
    logic                 w_stepAdv;
    logic                 w_advance;
    logic                 w_on;
    logic [NUM_LEDS-1:0]  w_next;
    logic                 w_nextDirRight;
    logic [NUM_LEDS-1:0]  w_newStart;
    logic [NUM_LEDS-1:0]  w_curStart;

    assign w_modeIn     = mode_t'(mode);
    assign w_modeChange = (w_modeIn != r_modeQ);
    assign w_stepAdv    = step & ~enable & ~load_divide & ~w_modeChange;
    assign w_advance    = w_presAdv | w_stepAdv;
    assign w_on         = (r_pwmCnt < brightness) | (&brightness);
    assign w_newStart   = startIsZero(w_modeIn) ? '0 : ONE_HOT_START;
    assign w_curStart   = startIsZero(r_modeQ)  ? '0 : ONE_HOT_START;

    tick_prescaler #(
        .DIV_WIDTH      (DIV_WIDTH),
        .DEFAULT_DIVIDE (DEFAULT_DIVIDE)
    ) u_prescaler (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_enable (enable),
        .i_load   (load_divide),
        .i_divide (divide),
        .i_clear  (w_modeChange),
        .o_adv    (w_presAdv)
    );

    // Bounce reverses on the same step that reaches an end bit, so the ends never dwell.
    always_comb begin
        w_next         = r_pattern;
        w_nextDirRight = r_dirRight;
        case (r_modeQ)
            MODE_ROT_L:  w_next = {r_pattern[NUM_LEDS-2:0], r_pattern[NUM_LEDS-1]};
            MODE_ROT_R:  w_next = {r_pattern[0], r_pattern[NUM_LEDS-1:1]};
            MODE_BOUNCE: begin
                if (r_dirRight) begin
                    if (r_pattern[0]) begin
                        w_next         = r_pattern << 1;
                        w_nextDirRight = 1'b0;
                    end else begin
                        w_next = r_pattern >> 1;
                    end
                end else begin
                    if (r_pattern[NUM_LEDS-1]) begin
                        w_next         = r_pattern >> 1;
                        w_nextDirRight = 1'b1;
                    end else begin
                        w_next = r_pattern << 1;
                    end
                end
            end
            MODE_COUNT:  w_next = r_pattern + 1'b1;
            default:     w_next = r_pattern;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_modeQ    <= MODE_ROT_L;
            r_pattern  <= ONE_HOT_START;
            r_dirRight <= 1'b0;
            r_pwmCnt   <= '0;
            leds       <= '0;
            tick       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            r_pwmCnt <= r_pwmCnt + 1'b1;
            leds     <= r_pattern & {NUM_LEDS{w_on}};
            tick     <= 1'b0;
            wrap     <= 1'b0;
            if (w_modeChange) begin
                r_modeQ    <= w_modeIn;
                r_pattern  <= w_newStart;
                r_dirRight <= 1'b0;
            end else if (w_advance) begin
                r_pattern  <= w_next;
                r_dirRight <= w_nextDirRight;
                tick       <= 1'b1;
                wrap       <= (w_next == w_curStart);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed scenarios followed by random stimulus, all checked cycle by cycle against a behavioural model.
module tb_led_pattern_sequencer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int DEF = 5;
    localparam int PW  = 4;
    localparam int FULL = 1 << N;
    localparam int HALF = 1 << (N - 1);
    localparam int BMAX = (1 << PW) - 1;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] divide;
    logic          load_divide;
    logic          step;
    logic [PW-1:0] brightness;
    logic [N-1:0]  leds;
    logic          tick;
    logic          wrap;

    int total = 0;
    int bad   = 0;

    int mDiv, mCnt, mMode, mPat, mPos, mPwm;
    bit mDirRight;
    logic [N-1:0] expLeds;
    logic         expTick, expWrap;

    int dutTicks, dutWraps, dutLed0;

    always #5 CLK = ~CLK;

    led_pattern_sequencer #(
        .NUM_LEDS       (N),
        .DIV_WIDTH      (DW),
        .DEFAULT_DIVIDE (DEF),
        .PWM_WIDTH      (PW)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .enable      (enable),
        .mode        (mode),
        .divide      (divide),
        .load_divide (load_divide),
        .step        (step),
        .brightness  (brightness),
        .leds        (leds),
        .tick        (tick),
        .wrap        (wrap)
    );

    function automatic int startOf(input int m);
        return (m == 3) ? 0 : 1;
    endfunction

    function automatic void modelReset();
        mDiv = DEF; mCnt = 0; mMode = 0; mPat = 1; mPos = 0; mPwm = 0;
        mDirRight = 1'b0;
        expLeds = '0; expTick = 1'b0; expWrap = 1'b0;
    endfunction

    // Pattern rules expressed as integer arithmetic on the pattern value or bounce position.
    function automatic void modelAdvance();
        case (mMode)
            0: mPat = (mPat * 2) % FULL + mPat / HALF;
            1: mPat = mPat / 2 + (mPat % 2) * HALF;
            2: begin
                if (mDirRight) begin
                    if (mPos == 0) begin mDirRight = 1'b0; mPos = 1; end
                    else mPos = mPos - 1;
                end else begin
                    if (mPos == N - 1) begin mDirRight = 1'b1; mPos = N - 2; end
                    else mPos = mPos + 1;
                end
                mPat = 1 << mPos;
            end
            default: mPat = (mPat + 1) % FULL;
        endcase
    endfunction

    function automatic void modelStep();
        bit on, adv;
        on = (mPwm < int'(brightness)) || (int'(brightness) == BMAX);
        expLeds = on ? N'(mPat) : '0;
        mPwm = (mPwm + 1) % (BMAX + 1);
        expTick = 1'b0;
        expWrap = 1'b0;
        adv = 1'b0;
        if (int'(mode) != mMode) begin
            mMode = int'(mode);
            mPat = startOf(mMode);
            mPos = 0;
            mDirRight = 1'b0;
            mCnt = 0;
            if (load_divide) mDiv = int'(divide);
        end else begin
            if (load_divide) begin
                mDiv = int'(divide);
                mCnt = 0;
            end else if (enable) begin
                if (mCnt == mDiv) begin adv = 1'b1; mCnt = 0; end
                else mCnt = mCnt + 1;
            end else if (step) begin
                adv = 1'b1;
            end
            if (adv) begin
                modelAdvance();
                expTick = 1'b1;
                expWrap = (mPat == startOf(mMode));
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("leds", 32'(leds), 32'(expLeds));
        check("tick", 32'(tick), 32'(expTick));
        check("wrap", 32'(wrap), 32'(expWrap));
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            modelStep();
            #1;
            checkOutput();
            dutTicks += int'(tick);
            dutWraps += int'(wrap);
            dutLed0  += int'(leds[0]);
        end
    endtask

    initial begin
        int bl[3];
        bl = '{4, 0, 15};
        RESET_N = 1'b0; enable = 1'b0; mode = 2'd0; divide = '0;
        load_divide = 1'b0; step = 1'b0; brightness = '0;
        modelReset();
        #12;
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Rotate-left at divide 3: one tick every four cycles, one wrap per lap.
        brightness = 4'hF; divide = 8'd3; load_divide = 1'b1;
        applyStimulus(1);
        load_divide = 1'b0; enable = 1'b1;
        dutTicks = 0; dutWraps = 0;
        applyStimulus(16);
        check("t1_ticks", 32'(dutTicks), 32'd4);
        check("t1_wraps", 32'(dutWraps), 32'd1);

        divide = 8'd0; load_divide = 1'b1;
        applyStimulus(1);
        load_divide = 1'b0; mode = 2'd2;
        applyStimulus(1);
        dutTicks = 0; dutWraps = 0;
        applyStimulus(8);
        check("t2_ticks", 32'(dutTicks), 32'd8);
        check("t2_wraps", 32'(dutWraps), 32'd1);

        mode = 2'd3;
        applyStimulus(1);
        dutTicks = 0; dutWraps = 0;
        applyStimulus(17);
        check("t3_ticks", 32'(dutTicks), 32'd17);
        check("t3_wraps", 32'(dutWraps), 32'd1);
        applyStimulus(5);
        mode = 2'd1;
        applyStimulus(1);
        check("t3_switchNoTick", 32'(tick), 32'd0);
        applyStimulus(1);
        check("t3_switchLeds", 32'(leds), 32'd1);

        enable = 1'b0;
        dutTicks = 0;
        for (int i = 0; i < 20; i++) begin
            step = (i == 3) || (i == 9) || (i == 15);
            applyStimulus(1);
        end
        step = 1'b0;
        check("t4_stepTicks", 32'(dutTicks), 32'd3);
        divide = 8'd7; load_divide = 1'b1;
        applyStimulus(1);
        load_divide = 1'b0; enable = 1'b1; step = 1'b1;
        dutTicks = 0;
        applyStimulus(8);
        step = 1'b0;
        check("t4_stepIgnored", 32'(dutTicks), 32'd1);

        enable = 1'b0; mode = 2'd0;
        applyStimulus(1);
        for (int k = 0; k < 3; k++) begin
            brightness = PW'(bl[k]);
            applyStimulus(1);
            dutLed0 = 0;
            applyStimulus(16);
            check("t5_pwmDuty", 32'(dutLed0), 32'((bl[k] == BMAX) ? 16 : bl[k]));
        end

        // Reset mid-bounce while heading right; release with bounce still selected.
        brightness = 4'hF; divide = 8'd0; load_divide = 1'b1; enable = 1'b1;
        applyStimulus(1);
        load_divide = 1'b0; mode = 2'd2;
        applyStimulus(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (mDirRight) break;
        end
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6_rstLeds", 32'(leds), 32'd0);
        check("t6_rstTick", 32'(tick), 32'd0);
        check("t6_rstWrap", 32'(wrap), 32'd0);
        modelReset();
        @(negedge CLK);
        RESET_N = 1'b1;
        dutTicks = 0;
        applyStimulus(13);
        check("t6_defaultDivTicks", 32'(dutTicks), 32'd2);

        for (int i = 0; i < 400; i++) begin
            enable      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            divide      = DW'($urandom_range(0, 4));
            load_divide = ($urandom_range(0, 14) == 0);
            step        = ($urandom_range(0, 3) == 0);
            brightness  = PW'($urandom_range(0, BMAX));
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised LED pattern engine for board-level status/heartbeat display. A programmable prescaler produces step ticks that advance an N-bit pattern register in one of four modes: rotate-left, rotate-right, bounce, binary count. Single-step while paused. Global PWM brightness gate on all outputs. Sits directly between board CLK and the LED pins.

Parameters:
NUM_LEDS, 4, LED count / pattern width (>=2)
DIV_WIDTH, 24, prescaler width
DEFAULT_DIVIDE, 400000, prescaler terminal count after reset (ticks every DEFAULT_DIVIDE+1 cycles)
PWM_WIDTH, 4, brightness resolution

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
enable  in  1  1 = free-run stepping; 0 = paused
mode  in  2  0 rot-left, 1 rot-right, 2 bounce, 3 binary count
divide  in  DIV_WIDTH  new prescaler terminal count
load_divide  in  1  pulse: latch divide
step  in  1  pulse: advance one step while paused
brightness  in  PWM_WIDTH  0 = off, all-ones = fully on
leds  out  NUM_LEDS  gated pattern
tick  out  1  one-cycle pulse per pattern advance
wrap  out  1  one-cycle pulse when pattern returns to its start value

Behaviour:
- Reset (async assert, sync release): div_reg=DEFAULT_DIVIDE, prescaler=0, pattern=1, dir=left, mode_q=0, pwm_cnt=0, leds=0, tick=0, wrap=0.
- Prescaler: if enable=1, count 0..div_reg. At count==div_reg: advance pulse, count->0. div_reg=0 -> advance every cycle. enable=0: count holds.
- load_divide=1: div_reg<=divide, prescaler<=0, no advance that cycle. If new div_reg < current count, no overflow past it (count was cleared).
- step: honoured only when enable=0. One advance per cycle step is high; ignored when enable=1.
- Advance (pattern update, same edge as tick=1):
  - rot-left: {p[N-2:0],p[N-1]}; rot-right: {p[0],p[N-1:1]}.
  - bounce: single hot bit moves per dir. At bit N-1, dir->right, same edge moves to N-2. At bit 0, dir->left, moves to 1. No dwell at ends.
  - count: p+1 modulo 2^N.
- Start value: 0 for count, 1 for all other modes.
- wrap=1 on the advance edge whose new pattern equals the start value:
  - rotate: MSB/LSB wrap.
  - bounce: 1->0 transition ending at bit 0.
  - count: all-ones->0.
- Mode change: mode != mode_q on a cycle -> mode_q<=mode, pattern<=start value of new mode, dir<=left, prescaler<=0. No tick/wrap that cycle. Mode change takes priority over advance and load_divide-driven clear.
- PWM: pwm_cnt free-runs every cycle regardless of enable. on = (pwm_cnt < brightness) | (brightness == all-ones).
- leds registered: leds <= pattern & {N{on}}. One-cycle latency from pattern/brightness change to pins.
- tick, wrap: registered one-cycle pulses aligned with the pattern update edge (leds reflects the new pattern one cycle later).
- Reset mid-operation: all state returns to reset values immediately. First post-reset cycle with mode!=0 performs a mode-change reload.

Decomposition:
- Package led_seq_pkg: mode constants MODE_ROT_L=0, MODE_ROT_R=1, MODE_BOUNCE=2, MODE_COUNT=3; typedef for 2-bit mode.
- Sub-module: tick_prescaler (DIV_WIDTH, DEFAULT_DIVIDE; inputs enable, load, divide, clear; output adv). Reusable for other timers.
- Pattern/PWM logic remains in top.

Test Plan:
- Reset, mode=0, divide loaded 3, brightness=15, enable=1 -> tick every 4 cycles; leds 0001,0010,0100,1000,0001; wrap on the 1000->0001 step only.
- mode=2, NUM_LEDS=4, div 0 -> pattern sequence 1,2,4,8,4,2,1,2. wrap on the 2->1 step.
- mode=3, div 0 -> pattern 0..15 then 0. wrap on the 15->0 step. Switch to mode 1 mid-count -> pattern=0001, no tick that cycle, prescaler restarts.
- enable=0, three 1-cycle step pulses over 20 cycles -> exactly 3 ticks, pattern advances 3. step with enable=1 -> no extra tick.
- brightness=4, pattern=0001 -> leds[0] high 4 of every 16 cycles. brightness=0 -> leds always 0. brightness=15 -> leds always high.
- Assert RESET_N low mid-bounce with dir=right -> leds/tick/wrap 0 immediately. After release, restarts at pattern 1, dir left, div_reg=DEFAULT_DIVIDE.
